// File: rtl/alu_seq_card_pkg.sv
// Shared configuration for the sequenced ALU card: op codes, FSM encoding, default widths.
// Pure declarations; no timing or flow control of its own.
package alu_seq_card_pkg;

  localparam int DATAWIDTH_DEF = 16;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic lez;
    logic zero;
    logic neg;
    logic carry;
  } flags_t;

endpackage

// File: rtl/alu_seq_card_if.sv
// Control/status bundle between a host sequencer and the ALU card; the shared data bus stays a plain inout.
// No flow control: the host polls done before reading with rd.
interface alu_seq_card_if #(
  parameter int DW = alu_seq_card_pkg::DATAWIDTH_DEF
) ();
  logic [DW-1:0] addr;
  logic [1:0]    op;
  logic          ld_a;
  logic          ld_b;
  logic          rd;
  logic          done;
  logic          lez;
  logic          zero;
  logic          neg;
  logic          carry;
  logic          rd_err;

  modport master (output addr, op, ld_a, ld_b, rd,
                  input  done, lez, zero, neg, carry, rd_err);
  modport slave  (input  addr, op, ld_a, ld_b, rd,
                  output done, lez, zero, neg, carry, rd_err);
endinterface

// File: rtl/alu_seq_card_core.sv
// Combinational ALU datapath: INC A+1, SUB B-A, ADD A+B, PASS B, with carry/borrow.
// Zero latency, no backpressure.
module alu_seq_core
  import alu_seq_card_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [1:0]           op,
  output logic [DATAWIDTH-1:0] result,
  output logic                 carry
);

  logic [DATAWIDTH:0] sum;

  // SUB borrow falls out of the extra bit: it is set exactly when A > B unsigned.
  always_comb begin
    sum = '0;
    case (op)
      OP_INC:  sum = {1'b0, a} + {{DATAWIDTH{1'b0}}, 1'b1};
      OP_SUB:  sum = {1'b0, b} - {1'b0, a};
      OP_ADD:  sum = {1'b0, a} + {1'b0, b};
      default: sum = {1'b0, b};
    endcase
  end

  assign result = sum[DATAWIDTH-1:0];
  assign carry  = sum[DATAWIDTH];

endmodule

// File: rtl/alu_seq_card.sv
// Sequenced ALU card: operand/op latches, IDLE/BUSY FSM and result/flag registers.
// Result valid CALC_CYCLES edges after the last load; a load while busy restarts the calculation.
module alu_seq_card
  import alu_seq_card_pkg::*;
#(
  parameter int DATAWIDTH   = DATAWIDTH_DEF,
  parameter int CALC_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inout  wire  [DATAWIDTH-1:0] data,
  alu_seq_card_if.slave        bus
);

  localparam logic [2:0] CNT_INIT = 3'(CALC_CYCLES - 1);
  localparam flags_t FLAGS_RST = '{lez: 1'b1, zero: 1'b1, neg: 1'b0, carry: 1'b0};

  logic [DATAWIDTH-1:0] a_q;
  logic [DATAWIDTH-1:0] b_q;
  logic [DATAWIDTH-1:0] result_q;
  logic [DATAWIDTH-1:0] src;
  logic [DATAWIDTH-1:0] core_res;
  logic [1:0]           op_q;
  logic [2:0]           cnt_q;
  logic [0:0]           state_q;
  logic                 core_carry;
  logic                 load;
  logic                 done;
  logic                 res_zero;
  logic                 res_neg;
  logic                 rd_err_q;
  flags_t               flags_q;
  flags_t               res_flags;

  assign load = bus.ld_a | bus.ld_b;
  assign done = (state_q == ST_IDLE);
  assign src  = (bus.op == OP_INC) ? bus.addr : data;
  assign data = bus.rd ? result_q : {DATAWIDTH{1'bz}};

  alu_seq_core #(.DATAWIDTH(DATAWIDTH)) u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (core_res),
    .carry  (core_carry)
  );

  // Flags are taken from the freshly computed result so they always land together with it.
  assign res_zero  = (core_res == '0);
  assign res_neg   = core_res[DATAWIDTH-1];
  assign res_flags = '{lez: res_neg | res_zero, zero: res_zero, neg: res_neg, carry: core_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      op_q     <= OP_INC;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      flags_q  <= FLAGS_RST;
      rd_err_q <= 1'b0;
    end else begin
      if (bus.rd && !done) begin
        rd_err_q <= 1'b1;
      end
      if (load) begin
        if (bus.ld_a) a_q <= src;
        if (bus.ld_b) b_q <= src;
        op_q    <= bus.op;
        cnt_q   <= CNT_INIT;
        state_q <= ST_BUSY;
      end else if (state_q == ST_BUSY) begin
        if (cnt_q == 3'd0) begin
          state_q  <= ST_IDLE;
          result_q <= core_res;
          flags_q  <= res_flags;
        end else begin
          cnt_q <= cnt_q - 3'd1;
        end
      end
    end
  end

  assign bus.done   = done;
  assign bus.lez    = flags_q.lez;
  assign bus.zero   = flags_q.zero;
  assign bus.neg    = flags_q.neg;
  assign bus.carry  = flags_q.carry;
  assign bus.rd_err = rd_err_q;

endmodule

// File: tb/tb_alu_seq_card.sv
// Bench for alu_seq_card: three instances (CALC_CYCLES 1, 2, 8) share one stimulus stream
// and are checked every cycle against an arithmetic model; directed literals pin the model.
module tb_alu_seq_card;
  import alu_seq_card_pkg::*;

  localparam int DW = 16;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0] addr;
  logic [DW-1:0] tb_dat;
  logic [1:0]    op;
  logic          ld_a;
  logic          ld_b;
  logic          rd;
  logic          chk_en;

  logic [NI-1:0] done_v, lez_v, zero_v, neg_v, carry_v, rd_err_v;
  logic [DW-1:0] data_v [NI];

  int n_chk = 0;
  int n_err = 0;

  function automatic int cc_of(int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 8);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int CC = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
    alu_seq_card_if #(.DW(DW)) bus ();
    wire [DW-1:0] data;
    assign data        = rd ? {DW{1'bz}} : tb_dat;
    assign bus.addr    = addr;
    assign bus.op      = op;
    assign bus.ld_a    = ld_a;
    assign bus.ld_b    = ld_b;
    assign bus.rd      = rd;
    assign done_v[g]   = bus.done;
    assign lez_v[g]    = bus.lez;
    assign zero_v[g]   = bus.zero;
    assign neg_v[g]    = bus.neg;
    assign carry_v[g]  = bus.carry;
    assign rd_err_v[g] = bus.rd_err;
    assign data_v[g]   = data;
    alu_seq_card #(.DATAWIDTH(DW), .CALC_CYCLES(CC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .data  (data),
      .bus   (bus)
    );
  end

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, g, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {carry, result}.
  function automatic logic [DW:0] alu_ref(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int unsigned ua, ub, r;
    logic c;
    ua = a;
    ub = b;
    case (o)
      2'd0:    begin r = ua + 1;  c = (r >= (32'd1 << DW)); end
      2'd1:    begin r = ub - ua; c = (ua > ub); end
      2'd2:    begin r = ua + ub; c = (r >= (32'd1 << DW)); end
      default: begin r = ub;      c = 1'b0; end
    endcase
    return {c, r[DW-1:0]};
  endfunction

  // Model: a load schedules completion CALC_CYCLES edges later; a later load reschedules.
  int unsigned   ec = 0;
  logic [DW-1:0] m_a [NI], m_b [NI], m_res [NI];
  logic [1:0]    m_op [NI];
  logic          m_pend [NI], m_carry [NI], m_err [NI];
  int unsigned   m_ready [NI];
  logic [DW-1:0] m_src;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NI; g++) begin
        m_a[g] = '0; m_b[g] = '0; m_res[g] = '0; m_op[g] = 2'd0;
        m_pend[g] = 1'b0; m_carry[g] = 1'b0; m_err[g] = 1'b0; m_ready[g] = 0;
      end
    end else begin
      ec++;
      for (int g = 0; g < NI; g++) begin
        if (rd && m_pend[g]) m_err[g] = 1'b1;
        m_src = (op == 2'd0) ? addr : (rd ? m_res[g] : tb_dat);
        if (ld_a || ld_b) begin
          if (ld_a) m_a[g] = m_src;
          if (ld_b) m_b[g] = m_src;
          m_op[g]    = op;
          m_pend[g]  = 1'b1;
          m_ready[g] = ec + cc_of(g);
        end else if (m_pend[g] && ec == m_ready[g]) begin
          {m_carry[g], m_res[g]} = alu_ref(m_op[g], m_a[g], m_b[g]);
          m_pend[g] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < NI; g++) begin
        chk("done",   g, done_v[g],   !m_pend[g]);
        chk("zero",   g, zero_v[g],   m_res[g] == '0);
        chk("neg",    g, neg_v[g],    m_res[g][DW-1]);
        chk("lez",    g, lez_v[g],    (m_res[g] == '0) || m_res[g][DW-1]);
        chk("carry",  g, carry_v[g],  m_carry[g]);
        chk("rd_err", g, rd_err_v[g], m_err[g]);
        if (rd) chk("data", g, data_v[g], m_res[g]);
      end
    end
  end

  task automatic do_load(input logic la, input logic lb, input logic [1:0] o,
                         input logic [DW-1:0] ad, input logic [DW-1:0] dt);
    ld_a = la; ld_b = lb; op = o; addr = ad; tb_dat = dt;
    @(posedge clk); #1;
    ld_a = 1'b0; ld_b = 1'b0;
  endtask

  task automatic lat_check(input string nm);
    int lat [NI];
    for (int g = 0; g < NI; g++) lat[g] = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      for (int g = 0; g < NI; g++) if (lat[g] < 0 && done_v[g]) lat[g] = e;
      if (lat[0] > 0 && lat[1] > 0 && lat[2] > 0) break;
    end
    for (int g = 0; g < NI; g++) chk(nm, g, lat[g], cc_of(g));
  endtask

  task automatic show(input string nm, input logic [DW-1:0] er,
                      input logic ec_, input logic ez, input logic en, input logic el);
    rd = 1'b1; #1;
    chk({nm, "_res"},   1, data_v[1],  er);
    chk({nm, "_carry"}, 1, carry_v[1], ec_);
    chk({nm, "_zero"},  1, zero_v[1],  ez);
    chk({nm, "_neg"},   1, neg_v[1],   en);
    chk({nm, "_lez"},   1, lez_v[1],   el);
    rd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; addr = '0; op = 2'd0; ld_a = 1'b0; ld_b = 1'b0; rd = 1'b0; tb_dat = '0;
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_done", 1, done_v[1], 1);
    chk("rst_zero", 1, zero_v[1], 1);
    chk("rst_lez",  1, lez_v[1],  1);
    chk("rst_err",  1, rd_err_v[1], 0);

    do_load(1, 0, OP_INC, 16'h00FF, 16'h0);
    chk("inc_busy", 1, done_v[1], 0);
    lat_check("inc_lat");
    show("inc", 16'h0100, 0, 0, 0, 0);

    do_load(1, 0, OP_SUB, 16'h0, 16'h0005);
    do_load(0, 1, OP_SUB, 16'h0, 16'h0003);
    lat_check("sub_lat");
    show("sub_neg", 16'hFFFE, 1, 0, 1, 1);
    do_load(0, 1, OP_SUB, 16'h0, 16'h0005);
    lat_check("sub0_lat");
    show("sub_zero", 16'h0000, 0, 1, 0, 1);

    do_load(1, 0, OP_ADD, 16'h0, 16'hFFFF);
    do_load(0, 1, OP_ADD, 16'h0, 16'h0001);
    lat_check("add_lat");
    show("add_wrap", 16'h0000, 1, 1, 0, 1);

    do_load(1, 0, OP_INC, 16'hFFFF, 16'h0);
    lat_check("incw_lat");
    show("inc_wrap", 16'h0000, 1, 1, 0, 1);

    do_load(1, 0, OP_ADD, 16'h0, 16'h0001);
    do_load(0, 1, OP_ADD, 16'h0, 16'h0010);
    lat_check("restart_lat");
    show("restart", 16'h0011, 0, 0, 0, 0);

    do_load(1, 0, OP_INC, 16'h0041, 16'h0);
    rd = 1'b1; #1;
    chk("rd_busy_data", 1, data_v[1], 16'h0011);
    @(posedge clk); #1;
    chk("rd_busy_err", 1, rd_err_v[1], 1);
    rd = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    do_load(1, 0, OP_ADD, 16'h0, 16'h0007);
    rst_n = 1'b0; #1;
    chk("rst_mid_done", 1, done_v[1], 1);
    chk("rst_mid_err",  1, rd_err_v[1], 0);
    chk("rst_mid_zero", 1, zero_v[1], 1);
    rd = 1'b1; #1;
    chk("rst_mid_data", 1, data_v[1], 16'h0000);
    rd = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    for (int i = 0; i < 3000; i++) begin
      op     = 2'($urandom_range(0, 3));
      addr   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      tb_dat = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      ld_a   = ($urandom_range(0, 11) == 0);
      ld_b   = ($urandom_range(0, 11) == 0);
      rd     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0; #1;
        rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end
    ld_a = 1'b0; ld_b = 1'b0; rd = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_card.md
ALU_SEQ_CARD -- requirements
Module: alu_seq_card

Interface
REQ-001 SHALL have parameter DATAWIDTH, default `DATAWIDTH (16): width of the data bus, address bus, operands and result.
REQ-002 SHALL have parameter CALC_CYCLES, default 1, legal range 1..8: clock cycles from operand load to result valid.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes occur on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port data  inout  DATAWIDTH: shared data bus; operand source for SUB/ADD, result destination.
REQ-006 SHALL have port addr  input  DATAWIDTH: address bus; operand source for INC.
REQ-007 SHALL have port op  input  2: operation (00 INC A+1, 01 SUB B-A, 10 ADD A+B, 11 PASS B).
REQ-008 SHALL have ports ld_a and ld_b  input  1 each: load operand A or B from the selected source.
REQ-009 SHALL have port rd  input  1: drive the result onto data.
REQ-010 SHALL have port done  output  1: result valid, no calculation pending.
REQ-011 SHALL have ports lez, zero, neg, carry  output  1 each: flags of the current result.
REQ-012 SHALL have port rd_err  output  1: sticky flag, set when rd is asserted while done=0.

Function
REQ-013 SHALL use source addr when op=INC and source data otherwise, combinationally.
REQ-014 SHALL, on a rising edge with ld_a or ld_b high, latch the source into A and/or B (both if both high), latch op, clear done, and load the cycle counter with CALC_CYCLES-1.
REQ-015 SHALL implement FSM states IDLE (done=1) and BUSY (done=0); IDLE->BUSY on any load; BUSY->IDLE when the counter is 0 at a rising edge.
REQ-016 SHALL decrement the counter on every BUSY edge without a load; on the BUSY->IDLE edge SHALL register the result and all flags together, so done rises exactly CALC_CYCLES edges after the load edge.
REQ-017 SHALL treat a load during BUSY as a restart: operand overwritten, op relatched, counter reloaded, done kept at 0.
REQ-018 SHALL compute the result modulo 2^DATAWIDTH; carry = carry-out for INC/ADD, borrow (A>B unsigned) for SUB, 0 for PASS.
REQ-019 SHALL derive zero = (result==0), neg = result MSB, and lez = neg|zero from the new result, never from the previous result.
REQ-020 SHALL drive data with the result register whenever rd=1, otherwise high-impedance, with no cycle delay.
REQ-021 SHALL set rd_err on a rising edge with rd=1 and done=0; only reset clears it.
REQ-022 SHALL give loads priority over counter completion when both occur on the same edge.

Reset
REQ-023 SHALL, while rst_n=0, immediately force A=0, B=0, result=0, op latch=INC, counter=0, state IDLE, done=1, zero=1, lez=1, neg=0, carry=0, rd_err=0.
REQ-024 SHALL abandon any BUSY calculation on reset without producing a result.
REQ-025 SHALL keep data high-impedance during reset unless rd=1, in which case it drives 0.

Structure
REQ-026 SHALL obtain the op encodings, the FSM state encoding and the DATAWIDTH default from the shared config header.
REQ-027 SHALL place result and flag computation in a purely combinational sub-module alu_seq_core (inputs A, B, op; outputs result, carry); the FSM, counter and registers remain in alu_seq_card.

Verification (DATAWIDTH=16, CALC_CYCLES=2 unless stated)
REQ-028 SHALL cover: ld_a with op=INC, addr=0x00FF -> done low for 2 edges, then result 0x0100, carry=0, lez=0.
REQ-029 SHALL cover: A=0x0005, B=0x0003, op=SUB -> result 0xFFFE, neg=1, lez=1, carry=1; with B=0x0005 -> result 0x0000, zero=1, lez=1.
REQ-030 SHALL cover: op=ADD with A=0xFFFF, B=0x0001 -> result 0x0000, carry=1, zero=1; INC with addr=0xFFFF -> result 0x0000, carry=1.
REQ-031 SHALL cover: ld_b=0x0010 reloaded one edge after the first load -> done rises 2 edges after the second load, result reflects 0x0010.
REQ-032 SHALL cover: rd pulsed while busy -> data shows the old result, rd_err=1; rst_n low mid-BUSY -> done=1, result=0, rd_err=0 immediately.
REQ-033 SHALL cover: CALC_CYCLES=1 and 8 -> done rises exactly 1 and 8 edges after the load.
